rf_wb_arbiter: RTL and testbench

- Write-back front end for the 32x32 RISC-V register file.
- Merges results from two producers (src0 = ALU, src1 = LSU) through valid/ready handshakes into one in-order FIFO.
- Drives the register file's single write port: write_enable, write_addr, write_data.
- Exports a per-register pending mask so decode can detect RAW hazards on results not yet written.

---
 rtl/rf_wb_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Write-back front end for the 32x32 RISC-V register file. Two result
// producers (src0 = ALU, src1 = LSU) hand results over through valid/ready
// handshakes. A round-robin arbiter accepts at most one per cycle into an
// in-order FIFO. The FIFO head drives the register file's single write port.
// A per-register pending mask lets decode see results that are queued but not
// yet written.
//
// Parameters:
//   DEPTH            FIFO entries (power of two, >= 2)
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   src0_valid_i     ALU result valid
//   src0_ready_o     ALU result accepted this cycle
//   src0_addr_i      ALU destination register
//   src0_data_i      ALU result
//   src1_valid_i     LSU result valid
//   src1_ready_o     LSU result accepted this cycle
//   src1_addr_i      LSU destination register
//   src1_data_i      LSU load data
//   stall_i          hold the write port; head is not popped
//   write_enable_o   register file write enable
//   write_addr_o     register file write address (FIFO head)
//   write_data_o     register file write data (FIFO head)
//   pending_o        bit k set while a queued entry targets x_k (bit 0 always 0)
//   empty_o          FIFO empty
//
// Optional feature, enabled by defining RF_WB_BYPASS_EN:
//   fwd_addr1_i/fwd_addr2_i   lookup addresses
//   fwd_hit1_o/fwd_hit2_o     a queued entry targets the lookup address
//   fwd_data1_o/fwd_data2_o   data of the youngest matching entry, 0 on miss
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        src0_valid_i,
    output logic        src0_ready_o,
    input  logic [4:0]  src0_addr_i,
    input  logic [31:0] src0_data_i,

    input  logic        src1_valid_i,
    output logic        src1_ready_o,
    input  logic [4:0]  src1_addr_i,
    input  logic [31:0] src1_data_i,

    input  logic        stall_i,

`ifdef RF_WB_BYPASS_EN
    input  logic [4:0]  fwd_addr1_i,
    input  logic [4:0]  fwd_addr2_i,
    output logic        fwd_hit1_o,
    output logic        fwd_hit2_o,
    output logic [31:0] fwd_data1_o,
    output logic [31:0] fwd_data2_o,
`endif

    output logic        write_enable_o,
    output logic [4:0]  write_addr_o,
    output logic [31:0] write_data_o,
    output logic [31:0] pending_o,
    output logic        empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [4:0]      addr_mem_q [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            rr_q, rr_d;

    // -------------------------------------------------------------------------
    // Status, arbitration and handshake
    // -------------------------------------------------------------------------
    logic        full;
    logic        empty;
    logic        grant0;
    logic        grant1;
    logic        push;
    logic        pop;
    logic [4:0]  push_addr;
    logic [31:0] push_data;

    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);

    // Readies look only at the other source's valid, never their own, so a
    // source may legally wait for ready before raising valid.
    assign src0_ready_o = !full && !rst_i && (!src1_valid_i || (rr_q == 1'b0));
    assign src1_ready_o = !full && !rst_i && (!src0_valid_i || (rr_q == 1'b1));

    assign grant0 = src0_valid_i && src0_ready_o;
    assign grant1 = src1_valid_i && src1_ready_o;

    // The two grants are mutually exclusive by construction.
    assign push_addr = grant1 ? src1_addr_i : src0_addr_i;
    assign push_data = grant1 ? src1_data_i : src0_data_i;

    // Writes to x0 are accepted and silently dropped.
    assign push = (grant0 || grant1) && (push_addr != 5'd0);

    // Reset also blocks the pop so a queued entry cannot reach the register
    // file on the same edge that discards it.
    assign pop = !empty && !stall_i && !rst_i;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_d     = rr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Only a contested grant moves the pointer; it then favours the loser.
        if (src0_valid_i && src1_valid_i && (grant0 || grant1)) begin
            rr_d = grant0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end

    // Storage needs no reset: an entry is only observed while count covers it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= push_addr;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    // -------------------------------------------------------------------------
    // Entry occupancy in age order
    // -------------------------------------------------------------------------
    // age_idx[k] is the physical slot of the k-th oldest entry.
    logic [PtrW-1:0] age_idx     [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    always_comb begin
        entry_valid = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            age_idx[k] = rd_ptr_q + PtrW'(k);
            if (CntW'(k) < count_q) begin
                entry_valid[age_idx[k]] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign write_enable_o = pop;
    assign write_addr_o   = addr_mem_q[rd_ptr_q];
    assign write_data_o   = data_mem_q[rd_ptr_q];
    assign empty_o        = empty || rst_i;

    always_comb begin
        pending_o = '0;
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entry_valid[i]) begin
                    pending_o[addr_mem_q[i]] = 1'b1;
                end
            end
        end
        pending_o[0] = 1'b0;
    end

`ifdef RF_WB_BYPASS_EN
    // Walk oldest to youngest so the last match seen is the youngest value.
    always_comb begin
        fwd_hit1_o  = 1'b0;
        fwd_hit2_o  = 1'b0;
        fwd_data1_o = '0;
        fwd_data2_o = '0;
        if (!rst_i) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (entry_valid[age_idx[k]] && (fwd_addr1_i != 5'd0) &&
                    (addr_mem_q[age_idx[k]] == fwd_addr1_i)) begin
                    fwd_hit1_o  = 1'b1;
                    fwd_data1_o = data_mem_q[age_idx[k]];
                end
                if (entry_valid[age_idx[k]] && (fwd_addr2_i != 5'd0) &&
                    (addr_mem_q[age_idx[k]] == fwd_addr2_i)) begin
                    fwd_hit2_o  = 1'b1;
                    fwd_data2_o = data_mem_q[age_idx[k]];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios followed by randomized
// traffic, checked against a queue-based reference model and a write-port
// scoreboard.
module tb_rf_wb_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        src0_valid, src0_ready;
    logic [4:0]  src0_addr;
    logic [31:0] src0_data;
    logic        src1_valid, src1_ready;
    logic [4:0]  src1_addr;
    logic [31:0] src1_data;
    logic        stall;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic        empty;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]  fwd_addr1, fwd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .src0_valid_i   (src0_valid),
        .src0_ready_o   (src0_ready),
        .src0_addr_i    (src0_addr),
        .src0_data_i    (src0_data),
        .src1_valid_i   (src1_valid),
        .src1_ready_o   (src1_ready),
        .src1_addr_i    (src1_addr),
        .src1_data_i    (src1_data),
        .stall_i        (stall),
`ifdef RF_WB_BYPASS_EN
        .fwd_addr1_i    (fwd_addr1),
        .fwd_addr2_i    (fwd_addr2),
        .fwd_hit1_o     (fwd_hit1),
        .fwd_hit2_o     (fwd_hit2),
        .fwd_data1_o    (fwd_data1),
        .fwd_data2_o    (fwd_data2),
`endif
        .write_enable_o (write_enable),
        .write_addr_o   (write_addr),
        .write_data_o   (write_data),
        .pending_o      (pending),
        .empty_o        (empty)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q0[$];   // results src0 still has to deliver
    ent_t q1[$];   // results src1 still has to deliver
    ent_t mq[$];   // model of the FIFO contents, oldest first
    ent_t sb[$];   // expected register-file writes, in order

    bit act0, act1;   // source currently holding valid
    bit g0, g1;       // model says source is accepted at the coming edge
    bit m_rr;         // model round-robin: 1 = src1 wins a contest
    int gap_pct;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

`ifdef RF_WB_BYPASS_EN
    function automatic void fwd_ref(input logic [4:0] fa, output logic hit,
                                    output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        foreach (mq[i]) begin
            if (fa != 5'd0 && mq[i].a == fa) begin
                hit  = 1'b1;
                data = mq[i].d;
            end
        end
    endfunction
`endif

    // Present the head of each source queue; once valid rises it holds.
    task automatic drive();
        if (!act0 && q0.size() > 0 && $urandom_range(99) >= gap_pct) act0 = 1'b1;
        if (!act1 && q1.size() > 0 && $urandom_range(99) >= gap_pct) act1 = 1'b1;
        src0_valid = act0;
        src1_valid = act1;
        if (act0) begin
            src0_addr = q0[0].a;
            src0_data = q0[0].d;
        end else begin
            src0_addr = 5'($urandom);
            src0_data = $urandom;
        end
        if (act1) begin
            src1_addr = q1[0].a;
            src1_data = q1[0].d;
        end else begin
            src1_addr = 5'($urandom);
            src1_data = $urandom;
        end
    endtask

    // Reference model, evaluated mid-cycle with inputs stable.
    task automatic model_step();
        logic        full_m, r0, r1, we;
        logic [31:0] pend;
`ifdef RF_WB_BYPASS_EN
        logic        h;
        logic [31:0] d;
`endif
        if (rst) begin
            chk("rst_ready0", 32'(src0_ready), 32'd0);
            chk("rst_ready1", 32'(src1_ready), 32'd0);
            chk("rst_write_enable", 32'(write_enable), 32'd0);
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_pending", pending, 32'd0);
            mq.delete();
            sb.delete();
            m_rr = 1'b0;
            g0   = 1'b0;
            g1   = 1'b0;
            return;
        end

        full_m = (mq.size() == DEPTH);
        r0 = !full_m && (!src1_valid || !m_rr);
        r1 = !full_m && (!src0_valid || m_rr);
        we = (mq.size() != 0) && !stall;
        pend = '0;
        foreach (mq[i]) pend[mq[i].a] = 1'b1;

        chk("ready0", 32'(src0_ready), 32'(r0));
        chk("ready1", 32'(src1_ready), 32'(r1));
        chk("write_enable", 32'(write_enable), 32'(we));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("pending", pending, pend);
`ifdef RF_WB_BYPASS_EN
        fwd_ref(fwd_addr1, h, d);
        chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
        chk("fwd_data1", fwd_data1, d);
        fwd_ref(fwd_addr2, h, d);
        chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
        chk("fwd_data2", fwd_data2, d);
`endif

        g0 = src0_valid && r0;
        g1 = src1_valid && r1;
        if (we) void'(mq.pop_front());
        if (g0 && q0[0].a != 5'd0) begin
            mq.push_back(q0[0]);
            sb.push_back(q0[0]);
        end
        if (g1 && q1[0].a != 5'd0) begin
            mq.push_back(q1[0]);
            sb.push_back(q1[0]);
        end
        if (src0_valid && src1_valid && (g0 || g1)) m_rr = g0;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (g0) begin
            void'(q0.pop_front());
            act0 = 1'b0;
        end
        if (g1) begin
            void'(q1.pop_front());
            act1 = 1'b0;
        end
        g0 = 1'b0;
        g1 = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Scoreboard monitor: every write the DUT presents must be the next one
    // expected.
    always @(negedge clk) begin
        ent_t e;
        if (write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_write: got addr %0d data 0x%08h expected no write",
                         write_addr, write_data);
            end else begin
                e = sb.pop_front();
                chk("write_addr", 32'(write_addr), 32'(e.a));
                chk("write_data", write_data, e.d);
            end
        end
    end

    initial begin
        int budget;
        rst     = 1'b1;
        stall   = 1'b0;
        gap_pct = 0;
        act0    = 1'b0;
        act1    = 1'b0;
        m_rr    = 1'b0;
`ifdef RF_WB_BYPASS_EN
        fwd_addr1 = 5'd0;
        fwd_addr2 = 5'd0;
`endif
        #1;
        run(2);
        rst = 1'b0;

        // Single ALU result: presented one cycle after acceptance.
        q0.push_back('{a: 5'd5, d: 32'hDEAD_BEEF});
        run(4);

        // Contested sources alternate.
        for (int i = 1; i <= 3; i++) begin
            q0.push_back('{a: 5'(i), d: 32'h100 + 32'(i)});
            q1.push_back('{a: 5'(i + 3), d: 32'h200 + 32'(i)});
        end
        run(10);

        // Fill under stall, then release.
        stall = 1'b1;
        for (int i = 7; i <= 12; i++) q1.push_back('{a: 5'(i), d: 32'h300 + 32'(i)});
        run(6);
        stall = 1'b0;
        run(10);

        // Write to x0 is swallowed.
        q0.push_back('{a: 5'd0, d: 32'h1234});
        run(4);

        // Same destination twice; lookup sees the youngest value.
        stall = 1'b1;
`ifdef RF_WB_BYPASS_EN
        fwd_addr1 = 5'd3;
`endif
        q0.push_back('{a: 5'd3, d: 32'hA});
        q0.push_back('{a: 5'd3, d: 32'hB});
        run(3);
        stall = 1'b0;
        run(4);

        // Reset with entries queued discards them.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) q0.push_back('{a: 5'(20 + i), d: 32'h400 + 32'(i)});
        run(4);
        rst = 1'b1;
        run(1);
        rst   = 1'b0;
        stall = 1'b0;
        run(3);

        // Randomized traffic.
        gap_pct = 30;
        for (int n = 0; n < 1500; n++) begin
            if (q0.size() < 3 && $urandom_range(2) == 0)
                q0.push_back('{a: ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7)),
                               d: $urandom});
            if (q1.size() < 3 && $urandom_range(2) == 0)
                q1.push_back('{a: ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7)),
                               d: $urandom});
            stall = ($urandom_range(99) < 30);
            rst   = ($urandom_range(199) == 0);
`ifdef RF_WB_BYPASS_EN
            fwd_addr1 = 5'($urandom_range(7));
            fwd_addr2 = 5'($urandom);
`endif
            cycle();
        end

        // Drain everything still outstanding.
        rst     = 1'b0;
        stall   = 1'b0;
        gap_pct = 0;
        budget  = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && budget < 200) begin
            cycle();
            budget++;
        end
        checks++;
        if (budget >= 200) begin
            failures++;
            $display("FAIL drain_timeout: got %0d writes outstanding expected 0", sb.size());
        end
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
